// File: rtl/mac_sequencer_if.sv
// Command, datapath and response signals of the scaled sum-of-elements sequencer.
interface mac_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_len;
    logic [DATA_W-1:0] cmd_scalar;

    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] b_data;
    logic [DATA_W-1:0] result_in;
    logic              w_lock;
    logic              busy;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [ACC_W-1:0]  rsp_sum;
    logic [ADDR_W:0]   rsp_count;

    modport slave (
        input  cmd_valid, cmd_base, cmd_len, cmd_scalar, result_in, rsp_ready,
        output cmd_ready, a_addr, b_data, w_lock, busy, rsp_valid, rsp_sum, rsp_count
    );

    modport master (
        output cmd_valid, cmd_base, cmd_len, cmd_scalar, result_in, rsp_ready,
        input  cmd_ready, a_addr, b_data, w_lock, busy, rsp_valid, rsp_sum, rsp_count
    );
endinterface

// File: rtl/mac_sequencer.sv
// Streams len regfile reads against a fixed scalar and sums the multiplier products; one response
// per command after len+MUL_LAT+1 cycles (1 for len=0); commands stall in every state but IDLE.
module mac_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 32,
    parameter int MUL_LAT = 3
) (
    input logic            clock,
    input logic            reset,
    mac_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_LEN = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [MUL_LAT-1:0]  vpipe_q, vpipe_d;
    logic                cmd_ready_q, rsp_valid_q, busy_q;
    logic                issue;
    logic [ADDR_W:0]     len_clamped;

    assign len_clamped = (bus.cmd_len > MAX_LEN) ? MAX_LEN : bus.cmd_len;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        b_d     = b_q;
        rem_d   = rem_q;
        count_d = count_q;
        acc_d   = acc_q;
        issue   = (state_q == ISSUE);
        vpipe_d = MUL_LAT'({vpipe_q, issue});

        // Tail of the valid pipe marks the product of the issue made MUL_LAT cycles ago.
        if (vpipe_q[MUL_LAT-1]) begin
            acc_d   = acc_q + ACC_W'(bus.result_in);
            count_d = count_q + ONE_LEN;
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    acc_d   = '0;
                    count_d = '0;
                    rem_d   = len_clamped;
                    if (len_clamped == '0) begin
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                        addr_d  = bus.cmd_base;
                        b_d     = bus.cmd_scalar;
                    end
                end
            end
            ISSUE: begin
                if (rem_q == ONE_LEN) begin
                    state_d = DRAIN;
                    addr_d  = '0;
                    b_d     = '0;
                end else begin
                    rem_d  = rem_q - ONE_LEN;
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (vpipe_d == '0) state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            vpipe_q     <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            b_q         <= b_d;
            rem_q       <= rem_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            vpipe_q     <= vpipe_d;
            cmd_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.a_addr    = addr_q;
    assign bus.b_data    = b_q;
    assign bus.w_lock    = busy_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = acc_q;
    assign bus.rsp_count = count_q;
endmodule
